// File: rtl/load_store_unit_if.sv
// ============================================================================
// Module   : load_store_unit_if
// Brief    : CPU-side request/response bundle of the load/store unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_fault
    );

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_fault
    );
endinterface

`default_nettype wire

// File: rtl/load_store_unit.sv
// ============================================================================
// Module   : load_store_unit
// Brief    : Single-outstanding load/store initiator for a word-addressed data
//            memory; read-modify-write for sub-word stores. Optional macro
//            LSU_MISALIGN_TRAP_EN turns misaligned half/word accesses into faults.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_store_unit #(
    parameter int MEM_WORDS = 64
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    load_store_unit_if.slave cpu,
    output logic [31:0]      mem_addr_o,
    input  wire logic [31:0] mem_read_i,
    output logic [31:0]      mem_write_data_o,
    output logic             mem_write_enable_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ACCESS = 3'd1,
        S_WRITE  = 3'd2,
        S_FAULT  = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    state_t      state_q;
    logic        write_q;
    logic [1:0]  size_q;
    logic        signed_q;
    logic [1:0]  off_q;
    logic [29:0] addr_q;
    logic [31:0] wdata_q;
    logic        ready_q;
    logic        resp_valid_q;
    logic [31:0] resp_rdata_q;
    logic        resp_fault_q;
    logic        we_q;
    logic [31:0] mem_wdata_q;

    logic        fault_d;
    logic [1:0]  off_d;
    logic [4:0]  shift_d;
    logic [7:0]  byte_d;
    logic [15:0] half_d;
    logic [31:0] load_d;
    logic [31:0] mask_d;
    logic [31:0] merge_d;

    always_comb begin
        fault_d = ({2'b00, cpu.req_addr[31:2]} >= 32'(MEM_WORDS));
`ifdef LSU_MISALIGN_TRAP_EN
        if ((cpu.req_size == 2'b01 && cpu.req_addr[0]) ||
            (cpu.req_size[1] && cpu.req_addr[1:0] != 2'b00)) begin
            fault_d = 1'b1;
        end
`endif
    end

    // Lane offset forced to the access size's alignment
    always_comb begin
        case (size_q)
            2'b00:   off_d = off_q;
            2'b01:   off_d = {off_q[1], 1'b0};
            default: off_d = 2'b00;
        endcase
        shift_d = {off_d, 3'b000};
        byte_d  = mem_read_i[shift_d +: 8];
        half_d  = mem_read_i[{off_d[1], 4'b0000} +: 16];
        case (size_q)
            2'b00: begin
                load_d = signed_q ? {{24{byte_d[7]}}, byte_d} : {24'd0, byte_d};
                mask_d = 32'h0000_00FF << shift_d;
            end
            2'b01: begin
                load_d = signed_q ? {{16{half_d[15]}}, half_d} : {16'd0, half_d};
                mask_d = 32'h0000_FFFF << shift_d;
            end
            default: begin
                load_d = mem_read_i;
                mask_d = 32'hFFFF_FFFF;
            end
        endcase
        merge_d = (mem_read_i & ~mask_d) | ((wdata_q << shift_d) & mask_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            write_q      <= 1'b0;
            size_q       <= 2'b00;
            signed_q     <= 1'b0;
            off_q        <= 2'b00;
            addr_q       <= 30'd0;
            wdata_q      <= 32'd0;
            ready_q      <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_fault_q <= 1'b0;
            we_q         <= 1'b0;
            mem_wdata_q  <= 32'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cpu.req_valid) begin
                        write_q  <= cpu.req_write;
                        size_q   <= cpu.req_size;
                        signed_q <= cpu.req_signed;
                        off_q    <= cpu.req_addr[1:0];
                        addr_q   <= cpu.req_addr[31:2];
                        wdata_q  <= cpu.req_wdata;
                        ready_q  <= 1'b0;
                        state_q  <= fault_d ? S_FAULT : S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (write_q) begin
                        mem_wdata_q <= merge_d;
                        we_q        <= 1'b1;
                        state_q     <= S_WRITE;
                    end else begin
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= load_d;
                        state_q      <= S_RESP;
                    end
                end
                S_WRITE: begin
                    we_q         <= 1'b0;
                    resp_valid_q <= 1'b1;
                    resp_rdata_q <= 32'd0;
                    state_q      <= S_RESP;
                end
                S_FAULT: begin
                    resp_valid_q <= 1'b1;
                    resp_fault_q <= 1'b1;
                    resp_rdata_q <= 32'd0;
                    state_q      <= S_RESP;
                end
                S_RESP: begin
                    resp_valid_q <= 1'b0;
                    resp_fault_q <= 1'b0;
                    resp_rdata_q <= 32'd0;
                    ready_q      <= 1'b1;
                    state_q      <= S_IDLE;
                end
                default: begin
                    we_q         <= 1'b0;
                    resp_valid_q <= 1'b0;
                    resp_fault_q <= 1'b0;
                    ready_q      <= 1'b1;
                    state_q      <= S_IDLE;
                end
            endcase
        end
    end

    assign cpu.req_ready       = ready_q;
    assign cpu.resp_valid      = resp_valid_q;
    assign cpu.resp_rdata      = resp_rdata_q;
    assign cpu.resp_fault      = resp_fault_q;
    assign mem_addr_o          = {addr_q, 2'b00};
    assign mem_write_data_o    = mem_wdata_q;
    assign mem_write_enable_o  = we_q;

endmodule

`default_nettype wire
